// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types, defaults and sizing helper for the multi-port register file
package reg_file_pkg;
  typedef enum logic {IDLE, CLEAR} rf_state_t;
  localparam int DW_DEF = 8;
  localparam int RAW_DEF = 4;
  function automatic int depth(input int raw);
    return 2 ** raw;
  endfunction
endpackage

// File: rtl/rf_clear_ctrl.sv
// rf_clear_ctrl: sequential clear FSM sweeping every entry after reset or on request
module rf_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int RAW = RAW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  output logic           busy,
  output logic           clr_we,
  output logic [RAW-1:0] clr_addr
);
  typedef logic [RAW:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(depth(RAW) - 1);
  rf_state_t state, state_nx;
  cnt_t cnt, cnt_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = (state == CLEAR) ? ((cnt == LAST) ? IDLE : CLEAR) : (clr_i ? CLEAR : IDLE);
    cnt_nx   = (state == CLEAR) ? cnt + 1'b1 : '0;
  end
  assign busy     = !rst_n || state == CLEAR;
  assign clr_we   = rst_n && state == CLEAR;
  assign clr_addr = cnt[RAW-1:0];
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: two-write, NRD-read register file with bypass, optional zero R0 and clear engine
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int RAW     = RAW_DEF,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][RAW-1:0]  rd_addr_i,
  output logic [NRD-1:0][DW-1:0]   rd_val_o,
  input  logic [1:0]               wen_i,
  input  logic [1:0][RAW-1:0]      wr_addr_i,
  input  logic [1:0][DW-1:0]       wr_data_i,
  input  logic                     clr_i,
  output logic                     busy_o
);
  localparam int DEPTH = depth(RAW);
  logic [DW-1:0] rf [DEPTH];
  logic clr_we;
  logic [RAW-1:0] clr_addr;
  logic [1:0] wr_ok;
  rf_clear_ctrl #(.RAW(RAW)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
    .busy(busy_o), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  assign wr_ok[0] = wen_i[0] && !(ZERO_R0 != 0 && wr_addr_i[0] == '0);
  assign wr_ok[1] = wen_i[1] && !(ZERO_R0 != 0 && wr_addr_i[1] == '0);
  // port 1 is assigned last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (!rst_n) rf[0] <= '0;
    else if (clr_we) rf[clr_addr] <= '0;
    else begin
      if (wr_ok[0]) rf[wr_addr_i[0]] <= wr_data_i[0];
      if (wr_ok[1]) rf[wr_addr_i[1]] <= wr_data_i[1];
    end
  end
  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic hit0, hit1, zero;
    assign zero = busy_o || (ZERO_R0 != 0 && rd_addr_i[r] == '0);
    assign hit0 = BYPASS != 0 && wen_i[0] && wr_addr_i[0] == rd_addr_i[r];
    assign hit1 = BYPASS != 0 && wen_i[1] && wr_addr_i[1] == rd_addr_i[r];
    assign rd_val_o[r] = zero ? '0 : hit1 ? wr_data_i[1] : hit0 ? wr_data_i[0] : rf[rd_addr_i[r]];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed bench for reg_file_mp with bypass and zero-R0 instances
module tb_reg_file_mp;
  logic clk = 0;
  logic rst_n;
  logic [1:0][3:0] rd_addr;
  logic [1:0][7:0] rd_val, rd_val_z;
  logic [1:0] wen;
  logic [1:0][3:0] wr_addr;
  logic [1:0][7:0] wr_data;
  logic clr;
  logic busy, busy_z;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DW(8), .RAW(4), .NRD(2), .BYPASS(1), .ZERO_R0(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_val_o(rd_val),
    .wen_i(wen), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .clr_i(clr), .busy_o(busy)
  );
  reg_file_mp #(.DW(8), .RAW(4), .NRD(2), .BYPASS(0), .ZERO_R0(1)) u_z (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_val_o(rd_val_z),
    .wen_i(wen), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .clr_i(clr), .busy_o(busy_z)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr[0] = 4'(i);
      rd_addr[1] = 4'(15 - i);
      #1;
      chk(tag, rd_val[0], 8'h00);
      chk(tag, rd_val[1], 8'h00);
      chk(tag, rd_val_z[0], 8'h00);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) begin
      wen = 2'b01;
      wr_addr[0] = 4'(i);
      wr_data[0] = v;
      tick();
    end
    wen = 2'b00;
  endtask

  initial begin
    rst_n = 0; wen = 0; clr = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    #1;
    chk("busy_in_reset", {7'd0, busy}, 8'h01);
    chk("busy_in_reset_z", {7'd0, busy_z}, 8'h01);
    repeat (3) tick();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      chk("busy_after_reset", {7'd0, busy}, 8'h01);
      tick();
    end
    chk("busy_drop_after_reset", {7'd0, busy}, 8'h00);
    chk("busy_drop_after_reset_z", {7'd0, busy_z}, 8'h00);
    check_all_zero("reset_clear_read");

    wen = 2'b01; wr_addr[0] = 4'd3; wr_data[0] = 8'hA5; rd_addr[0] = 4'd3;
    #1;
    chk("bypass_p0_same_cycle", rd_val[0], 8'hA5);
    chk("nobypass_p0_same_cycle", rd_val_z[0], 8'h00);
    tick();
    wen = 2'b10; wr_addr[1] = 4'd7; wr_data[1] = 8'h3C; rd_addr[1] = 4'd7;
    #1;
    chk("bypass_p1_same_cycle", rd_val[1], 8'h3C);
    chk("nobypass_p1_same_cycle", rd_val_z[1], 8'h00);
    chk("stored_addr3_next", rd_val[0], 8'hA5);
    tick();
    wen = 2'b00;
    #1;
    chk("stored_addr3", rd_val[0], 8'hA5);
    chk("stored_addr7", rd_val[1], 8'h3C);
    chk("stored_addr3_z", rd_val_z[0], 8'hA5);
    chk("stored_addr7_z", rd_val_z[1], 8'h3C);

    wen = 2'b11; wr_addr[0] = 4'd5; wr_addr[1] = 4'd5;
    wr_data[0] = 8'h11; wr_data[1] = 8'h22; rd_addr[0] = 4'd5;
    #1;
    chk("collision_bypass", rd_val[0], 8'h22);
    tick();
    wen = 2'b00;
    #1;
    chk("collision_stored", rd_val[0], 8'h22);
    chk("collision_stored_z", rd_val_z[0], 8'h22);

    wen = 2'b01; wr_addr[0] = 4'd0; wr_data[0] = 8'hFF; rd_addr[0] = 4'd0;
    #1;
    chk("zero_r0_same_cycle", rd_val_z[0], 8'h00);
    chk("r0_bypass_normal", rd_val[0], 8'hFF);
    tick();
    wen = 2'b00;
    #1;
    chk("zero_r0_after", rd_val_z[0], 8'h00);
    chk("r0_stored_normal", rd_val[0], 8'hFF);

    fill(8'h80);
    rd_addr[0] = 4'd2; rd_addr[1] = 4'd15;
    #1;
    chk("fill_addr2", rd_val[0], 8'h80);
    chk("fill_addr15_z", rd_val_z[1], 8'h80);
    clr = 1;
    #1;
    chk("busy_before_clr_edge", {7'd0, busy}, 8'h00);
    tick();
    clr = 0;
    for (int i = 0; i < 16; i++) begin
      wen = (i == 3) ? 2'b01 : 2'b00;
      wr_addr[0] = 4'd2; wr_data[0] = 8'h55;
      clr = (i == 5);
      #1;
      chk("busy_during_clr", {7'd0, busy}, 8'h01);
      if (i == 3) chk("read_zero_while_busy", rd_val[0], 8'h00);
      tick();
    end
    wen = 2'b00; clr = 0;
    #1;
    chk("busy_drop_after_clr", {7'd0, busy}, 8'h00);
    rd_addr[0] = 4'd2;
    #1;
    chk("write_dropped_while_busy", rd_val[0], 8'h00);
    check_all_zero("clr_read");

    fill(8'h80);
    clr = 1;
    tick();
    clr = 0;
    repeat (7) tick();
    rst_n = 0;
    #1;
    chk("busy_reset_mid_clear", {7'd0, busy}, 8'h01);
    tick();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      chk("busy_after_mid_reset", {7'd0, busy}, 8'h01);
      tick();
    end
    chk("busy_drop_after_mid_reset", {7'd0, busy}, 8'h00);
    check_all_zero("mid_reset_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Multi-ported, parametrised register file for the next-generation datapath.
- Configurable data width, depth and number of read ports; two write ports with defined collision priority.
- Optional write-to-read bypass and optional hardwired-zero R0.
- Built-in sequential clear engine: wipes the array after reset or on request, and flags busy while it runs.

Parameters:
- DW, 8, data width in bits.
- RAW, 4, address width; depth = 2**RAW entries.
- NRD, 2, number of independent combinational read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value.
- ZERO_R0, 0, 1 = address 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_addr_i  in  NRD x RAW  read addresses.
- rd_val_o  out  NRD x DW  read data; combinational.
- wen_i  in  2  write enables; [0] = port 0, [1] = port 1.
- wr_addr_i  in  2 x RAW  write addresses.
- wr_data_i  in  2 x DW  write data.
- clr_i  in  1  request a full clear; sampled in IDLE only.
- busy_o  out  1  clear in progress; writes ignored and reads return 0.

Behaviour:
- Reset (rst_n low at posedge):
  - state <= CLEAR, cnt <= 0, entry 0 <= 0.
  - busy_o = 1 while rst_n is low and throughout the clear.
  - Array contents other than entry 0 are undefined until cleared.
- Clear FSM, states IDLE and CLEAR:
  - CLEAR, each posedge: entry[cnt] <= 0, cnt <= cnt+1.
  - When cnt == 2**RAW-1, that entry is cleared and state <= IDLE.
  - After reset release, busy_o stays high for exactly 2**RAW posedges (entry 0 is recleared on the first one), then drops.
  - IDLE with clr_i=1 at posedge: state <= CLEAR, cnt <= 0. No entry is cleared on that edge; busy_o is high from the next cycle for 2**RAW cycles.
  - clr_i is ignored while in CLEAR (no restart).
  - rst_n low mid-clear restarts the clear from 0.
- Writes, IDLE only:
  - On posedge, RF[wr_addr_i[p]] <= wr_data_i[p] for each p with wen_i[p]=1.
  - If both ports are enabled to the same address, port 1 wins and port 0's write is discarded.
  - Writes presented while busy_o=1 are dropped silently.
- Reads, combinational, every port independent:
  - busy_o=1 -> 0.
  - ZERO_R0=1 and address 0 -> 0.
  - BYPASS=1 and a write to that address is enabled this cycle -> the winning write data, using port 1 priority.
  - Otherwise the stored value.
  - Bypass is suppressed when busy_o=1 or when ZERO_R0 applies.
- Width rules:
  - Data is stored and returned unmodified; no sign or zero extension.
  - cnt is RAW+1 bits wide, so the terminal compare does not wrap.
- No latency beyond the above: a write at edge N is visible with BYPASS=0 from cycle N+1 onward.

Decomposition:
- reg_file_pkg:
  - typedef enum logic {IDLE, CLEAR} rf_state_t.
  - localparam helper function depth(raw) = 2**raw.
  - Shared defaults DW_DEF=8 and RAW_DEF=4.
- Sub-module rf_clear_ctrl: owns the FSM and counter and outputs busy, clr_we and clr_addr. Only that FSM/counter logic goes in it.
- The array, write priority and read/bypass muxing stay in reg_file_mp (generate loop over NRD).

Test Plan:
- Reset with DW=8, RAW=4: hold rst_n low 3 cycles, then release -> busy_o high for exactly 16 cycles after release, then 0; every rd_val_o reads 0x00 for all 16 addresses.
- After the clear, write port0 addr 3 = 0xA5, then port1 addr 7 = 0x3C -> rd_addr 3/7 return 0xA5/0x3C the next cycle. With BYPASS=1, in the write cycle itself rd_addr 3 already shows 0xA5.
- Collision: wen_i=2'b11, both addresses = 5, data 0x11 (p0) and 0x22 (p1) -> RF[5]=0x22. With BYPASS=1, same-cycle read of 5 = 0x22.
- ZERO_R0=1: write 0xFF to address 0 -> reads of address 0 return 0x00 both same-cycle and after.
- clr_i pulse after filling addresses 0..15 with 0x80 -> busy_o rises next cycle for 16 cycles. A write of 0x55 to addr 2 during busy is dropped, so addr 2 reads 0x00 after. A second clr_i pulse mid-clear does not extend busy.
- rst_n low at clear cycle 8 of a clr_i-initiated clear -> busy continues, and a full 16-cycle clear runs after release; all entries read 0x00.
